// File: rtl/systolic_load_ctrl_pkg.sv
// ============================================================================
// sys_ctrl_pkg : shared types and sizes for the systolic load sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

package sys_ctrl_pkg;

  localparam int N_DIM      = 4;
  localparam int FEED_STEPS = 2*N_DIM-1;
  localparam int PERF_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_FEED   = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } sys_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/systolic_load_ctrl_if.sv
// ============================================================================
// systolic_load_ctrl_if : host command and datapath load/feed signals.
// Rev 1.0
// ============================================================================
`default_nettype none

interface systolic_load_ctrl_if #(
  parameter int FEED_W = 3
);
  logic              start;
  logic              abort;
  logic              src_valid;
  logic              done_ack;
  logic              dest_ready;
  logic              next_row;
  logic              next_col;
  logic              clear_acc;
  logic              feed_en;
  logic [FEED_W-1:0] feed_idx;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, src_valid, done_ack,
    output dest_ready, next_row, next_col, clear_acc, feed_en, feed_idx, busy, done
  );

  modport slave (
    output start, abort, src_valid, done_ack,
    input  dest_ready, next_row, next_col, clear_acc, feed_en, feed_idx, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/systolic_load_ctrl_step_counter.sv
// ============================================================================
// ctrl_step_counter : up-counter with sync clear, enable, wrap at LAST and tc.
// Rev 1.0
// ============================================================================
`default_nettype none

module ctrl_step_counter #(
  parameter int WIDTH = 3,
  parameter int LAST  = 6
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clr,
  input  wire logic             en,
  output logic      [WIDTH-1:0] count,
  output logic                  tc
);
  localparam logic [WIDTH-1:0] c_last = WIDTH'(LAST);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign tc    = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/systolic_load_ctrl.sv
// ============================================================================
// systolic_load_ctrl : clear / load / skewed-feed / drain sequencer for one
// 4x4 systolic pass. Optional perf counters under SYS_CTRL_PERF_EN. Rev 1.0
// ============================================================================
`default_nettype none

module systolic_load_ctrl #(
  parameter int N_DIM        = sys_ctrl_pkg::N_DIM,
  parameter int DRAIN_CYCLES = 4,
  parameter int FEED_W       = $clog2(2*N_DIM-1)
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  systolic_load_ctrl_if.master              bus
`ifdef SYS_CTRL_PERF_EN
  ,
  output logic [sys_ctrl_pkg::PERF_W-1:0]   perf_cycles,
  output logic [sys_ctrl_pkg::PERF_W-1:0]   perf_stalls
`endif
);
  import sys_ctrl_pkg::*;

  localparam int c_beat_w  = $clog2(N_DIM+1);
  localparam int c_drain_w = $clog2(DRAIN_CYCLES+1);

  sys_ctrl_state_t r_state, w_next;

  logic                 r_pulse;
  logic                 w_beat, w_beat_tc, w_feed_tc, w_drain_tc, w_cnt_clr;
  logic [c_beat_w-1:0]  w_beat_cnt;
  logic [c_drain_w-1:0] w_drain_cnt;
  logic [FEED_W-1:0]    w_feed_cnt;
  logic                 w_unused;

  assign w_beat    = (r_state == ST_LOAD) && bus.src_valid;
  assign w_cnt_clr = bus.abort || (r_state == ST_IDLE);
  assign w_unused  = ^{w_beat_cnt, w_drain_cnt};

  ctrl_step_counter #(.WIDTH(c_beat_w), .LAST(N_DIM-1)) u_beat_cnt (
    .clk(clk), .rst_n(rst_n), .clr(w_cnt_clr), .en(w_beat),
    .count(w_beat_cnt), .tc(w_beat_tc)
  );

  ctrl_step_counter #(.WIDTH(FEED_W), .LAST(2*N_DIM-2)) u_feed_cnt (
    .clk(clk), .rst_n(rst_n), .clr(w_cnt_clr), .en(r_state == ST_FEED),
    .count(w_feed_cnt), .tc(w_feed_tc)
  );

  ctrl_step_counter #(.WIDTH(c_drain_w), .LAST(DRAIN_CYCLES-1)) u_drain_cnt (
    .clk(clk), .rst_n(rst_n), .clr(w_cnt_clr), .en(r_state == ST_DRAIN),
    .count(w_drain_cnt), .tc(w_drain_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_next;
      // A beat taken in the abort cycle must not reach the datapath.
      r_pulse <= w_beat && !bus.abort;
    end
  end

  always_comb begin
    w_next         = r_state;
    bus.dest_ready = 1'b0;
    bus.clear_acc  = 1'b0;
    bus.feed_en    = 1'b0;
    bus.busy       = (r_state != ST_IDLE);
    bus.done       = 1'b0;
    unique case (r_state)
      ST_IDLE:   if (bus.start) w_next = ST_CLEAR;
      ST_CLEAR:  begin
        bus.clear_acc = 1'b1;
        w_next        = ST_LOAD;
      end
      ST_LOAD:   begin
        bus.dest_ready = 1'b1;
        if (w_beat && w_beat_tc) w_next = ST_SETTLE;
      end
      ST_SETTLE: w_next = ST_FEED;
      ST_FEED:   begin
        bus.feed_en = 1'b1;
        if (w_feed_tc) w_next = ST_DRAIN;
      end
      ST_DRAIN:  if (w_drain_tc) w_next = ST_DONE;
      ST_DONE:   begin
        bus.done = 1'b1;
        if (bus.done_ack) w_next = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
    if (bus.abort) w_next = ST_IDLE;
  end

  assign bus.next_row = r_pulse;
  assign bus.next_col = r_pulse;
  assign bus.feed_idx = w_feed_cnt;

`ifdef SYS_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_cycles, r_perf_stalls;
  logic              w_active;

  assign w_active = (r_state != ST_IDLE) && (r_state != ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if (bus.abort && (r_state != ST_IDLE)) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if ((r_state == ST_IDLE) && bus.start && !bus.abort) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if (w_active) begin
      if (r_perf_cycles != '1) r_perf_cycles <= r_perf_cycles + 1'b1;
      if ((r_state == ST_LOAD) && !bus.src_valid && (r_perf_stalls != '1))
        r_perf_stalls <= r_perf_stalls + 1'b1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule

`default_nettype wire

// File: tb/tb_systolic_load_ctrl.sv
// ============================================================================
// tb_systolic_load_ctrl : randomized pass-level checker for systolic_load_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_systolic_load_ctrl;
  localparam int c_n     = 4;
  localparam int c_drain = 4;
  localparam int c_fw    = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_load_ctrl_if #(.FEED_W(c_fw)) bus ();

`ifdef SYS_CTRL_PERF_EN
  logic [15:0] perf_cycles, perf_stalls;
`endif

  systolic_load_ctrl #(.N_DIM(c_n), .DRAIN_CYCLES(c_drain), .FEED_W(c_fw)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus)
`ifdef SYS_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls)
`endif
  );

  typedef struct {
    int         cyc;
    logic [9:0] exp;
    bit         start, abort, valid, ack, pchk;
    int         pc, ps;
  } step_t;

  step_t plan_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    p_n, p_abort_at;
  bit    p_aborted;

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Output vector: {busy, done, dest_ready, next_row, next_col, clear_acc, feed_en, feed_idx}
  function automatic logic [31:0] obs_vec();
    return {22'd0, bus.busy, bus.done, bus.dest_ready, bus.next_row, bus.next_col,
            bus.clear_acc, bus.feed_en, bus.feed_idx};
  endfunction

  function automatic logic [9:0] mk(bit busy, bit done, bit dr, bit pulse, bit clr,
                                    bit fe, logic [2:0] idx);
    return {busy, done, dr, pulse, pulse, clr, fe, idx};
  endfunction

  task automatic push(logic [9:0] exp, bit st, bit va, bit ack, bit pchk, int pc, int ps);
    step_t s;
    if (p_aborted) return;
    s.cyc = p_n; s.exp = exp; s.start = st; s.valid = va; s.ack = ack;
    s.abort = (p_n == p_abort_at); s.pchk = pchk; s.pc = pc; s.ps = ps;
    if (s.abort) begin
      p_aborted = 1'b1;
      s.start   = 1'b0;
    end
    plan_q.push_back(s);
    p_n++;
  endtask

  function automatic bit rbit(bit rnd, bit dflt);
    return rnd ? bit'($urandom_range(0, 1)) : dflt;
  endfunction

  // Build the expected timeline of one pass from its phase lengths.
  task automatic plan_pass(bit rnd, logic [31:0] stall_mask, int ack_delay, int abort_at);
    int beats, stalls, li, total;
    bit pulse, v;
    p_n = 0; p_aborted = 1'b0; p_abort_at = abort_at;
    push(mk(0,0,0,0,0,0,0), 1'b1, rbit(rnd, 1'b1), 1'b0, 1'b0, 0, 0);
    push(mk(1,0,0,0,1,0,0), rbit(rnd, 1'b0), rbit(rnd, 1'b1), 1'b0, 1'b0, 0, 0);
    beats = 0; stalls = 0; li = 0; pulse = 1'b0;
    while (beats < c_n) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : !stall_mask[li];
      push(mk(1,0,1,pulse,0,0,0), rbit(rnd, 1'b0), v, 1'b0, 1'b0, 0, 0);
      pulse = v; beats += int'(v); stalls += int'(!v); li++;
    end
    push(mk(1,0,0,pulse,0,0,0), rbit(rnd, 1'b0), rbit(rnd, 1'b1), 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 2*c_n-1; k++)
      push(mk(1,0,0,0,0,1,3'(k)), rbit(rnd, 1'b0), rbit(rnd, 1'b1), 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < c_drain; k++)
      push(mk(1,0,0,0,0,0,0), rbit(rnd, 1'b0), rbit(rnd, 1'b1), 1'b0, 1'b0, 0, 0);
    total = 1 + li + 1 + (2*c_n-1) + c_drain;
    for (int d = 0; d <= ack_delay; d++)
      push(mk(1,1,0,0,0,0,0), rbit(rnd, d == ack_delay), rbit(rnd, 1'b1), d == ack_delay,
           d == 0, total, stalls);
    push(mk(0,0,0,0,0,0,0), 1'b0, rbit(rnd, 1'b1), 1'b0, 1'b0, 0, 0);
  endtask

  task automatic run_plan(int max);
    step_t s;
    int    k = 0;
    while (plan_q.size() > 0 && (max < 0 || k < max)) begin
      s = plan_q.pop_front();
      check_eq($sformatf("cyc%0d", s.cyc), obs_vec(), {22'd0, s.exp});
`ifdef SYS_CTRL_PERF_EN
      if (s.pchk) begin
        check_eq("perf_cycles", {16'd0, perf_cycles}, s.pc);
        check_eq("perf_stalls", {16'd0, perf_stalls}, s.ps);
      end
`endif
      bus.start = s.start; bus.abort = s.abort; bus.src_valid = s.valid; bus.done_ack = s.ack;
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic drive_idle();
    bus.start = 1'b0; bus.abort = 1'b0; bus.src_valid = 1'b0; bus.done_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", obs_vec(), 32'd0);
`ifdef SYS_CTRL_PERF_EN
    check_eq("reset_perf", {perf_cycles, perf_stalls}, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    plan_pass(1'b0, 32'h0, 1, -1);  run_plan(-1);   // nominal, ack in cycle 19
    plan_pass(1'b0, 32'h6, 0, -1);  run_plan(-1);   // stalls in cycles 3 and 4
    plan_pass(1'b0, 32'h0, 0, 9);   run_plan(-1);   // abort during FEED
    plan_pass(1'b0, 32'h0, 0, -1);  run_plan(-1);

    plan_pass(1'b0, 32'h0, 0, -1);  run_plan(4);    // reset lands in LOAD, cycle 4
    plan_q.delete();
    drive_idle();
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset_outs", obs_vec(), 32'd0);
`ifdef SYS_CTRL_PERF_EN
    check_eq("async_reset_perf", {perf_cycles, perf_stalls}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 check_eq("held_reset_outs", obs_vec(), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    plan_pass(1'b0, 32'h0, 2, -1);  run_plan(-1);

    for (int t = 0; t < 30; t++) begin
      plan_pass(1'b1, 32'h0, int'($urandom_range(0, 12)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25)) : -1);
      run_plan(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
